// File: rtl/lsu_prf_wb_sched_pkg.sv
// Shared constants and types for the LSU PRF writeback scheduler.
// Defaults describe two L1D data pipes plus the bus refill path.
package lsu_prf_wb_sched_pkg;

  localparam int LSU_WB_SRC_COUNT       = 3;
  localparam int LSU_WB_FIFO_DEPTH      = 2;
  localparam int LSU_WB_BUS_SRC         = LSU_WB_SRC_COUNT - 1;
  localparam int LSU_PHY_REG_ADDR_WIDTH = 6;
  localparam int LSU_XLEN               = 64;
  localparam int LSU_ROB_INDEX_WIDTH    = 6;

  // Once a write is offered and stalled, the grant stays parked on it.
  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/lsu_wb_src_fifo.sv
// Per-source writeback FIFO: one enqueue, one dequeue, synchronous flush.
// The head appears the cycle after enqueue; there is no same-cycle bypass.
module lsu_wb_src_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_i,
  input  logic [WIDTH-1:0] enq_data_i,
  input  logic             deq_i,
  output logic             head_vld_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_i) begin
        mem_d[wr_ptr_q] = enq_data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (deq_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq_i, deq_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_vld_o  = (count_q != '0);
  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(enq_i && count_q == CNT_W'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(deq_i && count_q == '0));

endmodule

// File: rtl/lsu_prf_wb_sched.sv
// Round-robin arbiter sharing the LSU PRF write port among load-result sources,
// holding a stalled grant until the PRF accepts it.
module lsu_prf_wb_sched
  import lsu_prf_wb_sched_pkg::*;
#(
  parameter int SRC_COUNT          = LSU_WB_SRC_COUNT,
  parameter int FIFO_DEPTH         = LSU_WB_FIFO_DEPTH,
  parameter int PHY_REG_ADDR_WIDTH = LSU_PHY_REG_ADDR_WIDTH,
  parameter int XLEN               = LSU_XLEN,
  parameter int ROB_INDEX_WIDTH    = LSU_ROB_INDEX_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    flush,
  input  logic [SRC_COUNT-1:0]                    src_vld_i,
  output logic [SRC_COUNT-1:0]                    src_rdy_o,
  input  logic [SRC_COUNT*PHY_REG_ADDR_WIDTH-1:0] src_rd_addr_i,
  input  logic [SRC_COUNT*XLEN-1:0]               src_data_i,
  input  logic [SRC_COUNT*ROB_INDEX_WIDTH-1:0]    src_rob_index_i,
  input  logic                                    prf_rdy_i,
  output logic                                    prf_wb_vld_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0]           prf_wb_rd_addr_o,
  output logic [XLEN-1:0]                         prf_wb_data_o,
  output logic [ROB_INDEX_WIDTH-1:0]              prf_wb_rob_index_o,
  output logic [SRC_COUNT-1:0]                    prf_wb_src_o
);

  localparam int SRC_W   = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
  localparam int ENTRY_W = PHY_REG_ADDR_WIDTH + XLEN + ROB_INDEX_WIDTH;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [SRC_COUNT-1:0] head_vld, enq, deq;
  logic [ENTRY_W-1:0]   head_data  [SRC_COUNT];
  logic [CNT_W-1:0]     fifo_count [SRC_COUNT];

  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] locked_src_q, locked_src_d;
  arb_state_e       arb_state_q, arb_state_d;

  logic [SRC_W-1:0]     pick_idx, grant_idx;
  logic                 pick_found, wb_vld, pop;
  logic [SRC_COUNT-1:0] grant_oh;
  logic [ENTRY_W-1:0]   wb_entry;
  int                   cand;

  for (genvar k = 0; k < SRC_COUNT; k++) begin : g_src
    assign src_rdy_o[k] = (fifo_count[k] < CNT_W'(FIFO_DEPTH)) & ~rst;
    assign enq[k]       = src_vld_i[k] & src_rdy_o[k];
    assign deq[k]       = pop & (grant_idx == SRC_W'(k));

    lsu_wb_src_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .enq_i       (enq[k]),
      .enq_data_i  ({src_rd_addr_i[k*PHY_REG_ADDR_WIDTH +: PHY_REG_ADDR_WIDTH],
                     src_data_i[k*XLEN +: XLEN],
                     src_rob_index_i[k*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH]}),
      .deq_i       (deq[k]),
      .head_vld_o  (head_vld[k]),
      .head_data_o (head_data[k]),
      .count_o     (fifo_count[k])
    );
  end

  // First valid head at or after rr_ptr, wrapping around the source list.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < SRC_COUNT; i++) begin
      cand = (int'(rr_ptr_q) + i) % SRC_COUNT;
      if (!pick_found && head_vld[SRC_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = SRC_W'(cand);
      end
    end
  end

  assign grant_idx = (arb_state_q == ARB_LOCKED) ? locked_src_q : pick_idx;
  assign wb_vld    = (|head_vld) & ~flush & ~rst;
  assign pop       = wb_vld & prf_rdy_i;

  always_comb begin
    grant_oh = '0;
    wb_entry = '0;
    if (wb_vld) begin
      grant_oh[grant_idx] = 1'b1;
      wb_entry            = head_data[grant_idx];
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    arb_state_d  = arb_state_q;
    locked_src_d = locked_src_q;
    if (flush) begin
      rr_ptr_d    = '0;
      arb_state_d = ARB_FREE;
    end else if (pop) begin
      rr_ptr_d    = (grant_idx == SRC_W'(SRC_COUNT - 1)) ? '0 : grant_idx + SRC_W'(1);
      arb_state_d = ARB_FREE;
    end else if (wb_vld) begin
      arb_state_d  = ARB_LOCKED;
      locked_src_d = grant_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      arb_state_q  <= ARB_FREE;
      locked_src_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      arb_state_q  <= arb_state_d;
      locked_src_q <= locked_src_d;
    end
  end

  assign prf_wb_vld_o = wb_vld;
  assign prf_wb_src_o = grant_oh;
  assign {prf_wb_rd_addr_o, prf_wb_data_o, prf_wb_rob_index_o} = wb_entry;

  a_src_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(prf_wb_src_o));
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (prf_wb_vld_o && !prf_rdy_i) |=> (flush || $stable({prf_wb_src_o, prf_wb_rd_addr_o,
                                                         prf_wb_data_o, prf_wb_rob_index_o})));

endmodule
